// File: rtl/key_pkg.sv
// Shared types and defaults for the key debounce/press classifier.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } key_state_t;

    // Defaults assume a 50 MHz system clock: 20 ms, 1 s, 200 ms.
    localparam int KEY_DEBOUNCE_DEF = 1_000_000;
    localparam int KEY_LONG_DEF     = 50_000_000;
    localparam int KEY_REPEAT_DEF   = 10_000_000;

    // Raw pin level that means "pressed".
    localparam logic KEY_PRESSED = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..max_val-1; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous input pin.
// The reset value is a parameter so the idle level of any pin can be loaded.
module key_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from the same edge and shift as a true pipeline.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce_press.sv
// Debounces one active-low push-button and emits press/release/long pulses.
// Define KEY_REPEAT_EN to build the auto-repeat counter that drives key_repeat.
module key_debounce_press
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
    parameter int LONG_CYCLES     = KEY_LONG_DEF,
    parameter int REPEAT_CYCLES   = KEY_REPEAT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic long_press,
    output logic key_repeat
);

`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int MAX_P = max2(max2(DEBOUNCE_CYCLES, LONG_CYCLES), REP_EN ? REPEAT_CYCLES : 1);
    localparam int CW    = cnt_width(MAX_P);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic w_key_sync;
    logic w_pressed;

    key_state_t    r_state,       w_state_nxt;
    logic [CW-1:0] r_cnt,         w_cnt_nxt;
    logic [CW-1:0] r_hold_cnt,    w_hold_nxt;
    logic          r_long_done,   w_long_done_nxt;
    logic          r_key_level,   w_level_nxt;
    logic          r_key_press,   w_press_nxt;
    logic          r_key_release, w_release_nxt;
    logic          r_long_press,  w_long_nxt;

    key_sync #(
        .RST_VAL (~KEY_PRESSED)
    ) u_key_sync (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (key_n),
        .o_q     (w_key_sync)
    );

    assign w_pressed = (w_key_sync == KEY_PRESSED);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hold_nxt      = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = r_key_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                w_level_nxt = 1'b0;
                if (w_pressed) begin
                    w_state_nxt = DB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!w_pressed) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt     = HELD;
                    w_press_nxt     = 1'b1;
                    w_level_nxt     = 1'b1;
                    w_hold_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = DB_RELEASE;
                    w_cnt_nxt   = '0;
                end else if (r_hold_cnt == LONG_LAST) begin
                    // Saturated: the long pulse fires once, then the count parks here.
                    if (!r_long_done) begin
                        w_long_nxt      = 1'b1;
                        w_long_done_nxt = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + CNT_ONE;
                end
            end
            DB_RELEASE: begin
                if (w_pressed) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_hold_cnt    <= '0;
            r_long_done   <= 1'b0;
            r_key_level   <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            r_long_press  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_long_done   <= w_long_done_nxt;
            r_key_level   <= w_level_nxt;
            r_key_press   <= w_press_nxt;
            r_key_release <= w_release_nxt;
            r_long_press  <= w_long_nxt;
        end
    end

    assign key_level   = r_key_level;
    assign key_press   = r_key_press;
    assign key_release = r_key_release;
    assign long_press  = r_long_press;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] r_rep_cnt, w_rep_nxt;
    logic          r_key_repeat, w_repeat_nxt;

    // Runs only after the long press; frozen in DB_RELEASE, cleared in IDLE.
    always_comb begin
        w_rep_nxt    = r_rep_cnt;
        w_repeat_nxt = 1'b0;
        if (r_state == IDLE) begin
            w_rep_nxt = '0;
        end else if (w_long_nxt) begin
            w_rep_nxt = '0;
        end else if (r_state == HELD && w_pressed && r_long_done) begin
            if (r_rep_cnt == REP_LAST) begin
                w_rep_nxt    = '0;
                w_repeat_nxt = 1'b1;
            end else begin
                w_rep_nxt = r_rep_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rep_cnt    <= '0;
            r_key_repeat <= 1'b0;
        end else begin
            r_rep_cnt    <= w_rep_nxt;
            r_key_repeat <= w_repeat_nxt;
        end
    end

    assign key_repeat = r_key_repeat;
`else
    assign key_repeat = 1'b0;
`endif

endmodule
